pipeline_hazard_ctrl: RTL and testbench

//  Sequential stall/flush controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
//  It owns every pipeline-register enable and flush.
//  It inserts load-use bubbles, squashes wrong-path instructions on EX redirects, freezes the core on data-memory wait, and drains/halts on opcode 0.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 45 ++++
 rtl/pipeline_hazard_ctrl_if.sv | 37 +++
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 24 ++
 rtl/pipeline_hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and control-bundle type for the pipeline
// stall/flush controller.
package pipeline_hazard_ctrl_pkg;

  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  // An all-zero opcode is the halt marker; it is not a legal RV32I encoding.
  localparam logic [6:0] OPCODE_HALT   = 7'b0000000;

  typedef enum logic [1:0] {
    HZ_ST_RUN        = 2'd0,
    HZ_ST_LOAD_STALL = 2'd1,
    HZ_ST_DRAIN      = 2'd2,
    HZ_ST_HALT       = 2'd3
  } hz_state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic if_id_flush;
    logic id_ex_flush;
  } hz_ctrl_t;

  // Everything frozen: used in reset, HALT and data-memory wait.
  localparam hz_ctrl_t CTRL_NONE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam hz_ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  // Front end holds, a NOP enters EX, older instructions keep moving.
  localparam hz_ctrl_t CTRL_BUBBLE = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam hz_ctrl_t CTRL_REDIR  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  function automatic logic uses_rs1(input logic [6:0] opc);
    return !(opc == OPCODE_LUI || opc == OPCODE_AUIPC || opc == OPCODE_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    return (opc == OPCODE_BRANCH || opc == OPCODE_STORE || opc == OPCODE_OP);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle. The datapath (master) drives stage
// information and the dmem handshake; the controller (slave) returns enables.
interface pipeline_hazard_ctrl_if;
  // Handshake: dmem_req marks a MEM-stage access in flight and dmem_ack
  // completes it in the same cycle; any cycle with req=1 and ack=0 is a wait
  // cycle in which the whole pipeline must hold.
  logic [6:0] id_opc;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       ex_is_load;
  logic [4:0] ex_rd;
  logic       ex_redirect;
  logic       dmem_req;
  logic       dmem_ack;

  logic       pc_en;
  logic       if_id_en;
  logic       id_ex_en;
  logic       ex_mem_en;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       halted;

  modport master (
    output id_opc, id_rs1, id_rs2, ex_is_load, ex_rd, ex_redirect,
           dmem_req, dmem_ack,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
           halted
  );

  modport slave (
    input  id_opc, id_rs1, id_rs2, ex_is_load, ex_rd, ex_redirect,
           dmem_req, dmem_ack,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
           halted
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use detector: a LOAD in EX whose rd feeds a source
// register that the instruction in ID actually reads.
module pipeline_hazard_ctrl_hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [6:0] id_opc,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       ex_is_load,
  input  logic [4:0] ex_rd,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit = (ex_rd == id_rs1) && uses_rs1(id_opc);
    rs2_hit = (ex_rd == id_rs2) && uses_rs2(id_opc);
    // x0 is never written, so a load targeting it cannot create a hazard.
    load_use = ex_is_load && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage RV32I pipeline: load-use bubbles,
// redirect squash, dmem wait freeze and halt drain, plus a stall counter.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int DRAIN_CYCLES     = 4,
  parameter int CNT_W            = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave bus,
  output logic [CNT_W-1:0]      stall_count,
  output hz_state_e             dbg_state
);

  localparam logic [2:0] BUB_INIT = 3'(LOAD_USE_BUBBLES - 1);
  localparam logic [3:0] DRN_INIT = 4'(DRAIN_CYCLES - 1);

  hz_state_e  state;
  hz_state_e  state_nx;
  logic [2:0] bub_cnt;
  logic [2:0] bub_nx;
  logic [3:0] drn_cnt;
  logic [3:0] drn_nx;
  hz_ctrl_t   ctrl;
  logic       load_use;
  logic       mem_wait;

  pipeline_hazard_ctrl_hazard_detect u_detect (
    .id_opc     (bus.id_opc),
    .id_rs1     (bus.id_rs1),
    .id_rs2     (bus.id_rs2),
    .ex_is_load (bus.ex_is_load),
    .ex_rd      (bus.ex_rd),
    .load_use   (load_use)
  );

  assign mem_wait = bus.dmem_req && !bus.dmem_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= HZ_ST_RUN;
      bub_cnt <= '0;
      drn_cnt <= '0;
    end else begin
      state   <= state_nx;
      bub_cnt <= bub_nx;
      drn_cnt <= drn_nx;
    end
  end

  // Counters hold the number of stall cycles still owed in the current state;
  // a value of 1 (or less) means this is the last one.
  always_comb begin
    ctrl     = CTRL_NONE;
    state_nx = state;
    bub_nx   = bub_cnt;
    drn_nx   = drn_cnt;
    if (!rst && state != HZ_ST_HALT) begin
      if (mem_wait) begin
        ctrl = CTRL_NONE;
      end else if (bus.ex_redirect) begin
        // Whatever was stalled or draining is on the wrong path.
        ctrl     = CTRL_REDIR;
        state_nx = HZ_ST_RUN;
        bub_nx   = '0;
        drn_nx   = '0;
      end else begin
        case (state)
          HZ_ST_RUN: begin
            if (load_use) begin
              ctrl = CTRL_BUBBLE;
              if (LOAD_USE_BUBBLES > 1) begin
                state_nx = HZ_ST_LOAD_STALL;
                bub_nx   = BUB_INIT;
              end
            end else if (bus.id_opc == OPCODE_HALT) begin
              ctrl = CTRL_BUBBLE;
              if (DRAIN_CYCLES > 1) begin
                state_nx = HZ_ST_DRAIN;
                drn_nx   = DRN_INIT;
              end else begin
                state_nx = HZ_ST_HALT;
              end
            end else begin
              ctrl = CTRL_RUN;
            end
          end
          HZ_ST_LOAD_STALL: begin
            ctrl = CTRL_BUBBLE;
            if (bub_cnt <= 3'd1) begin
              state_nx = HZ_ST_RUN;
              bub_nx   = '0;
            end else begin
              bub_nx = bub_cnt - 3'd1;
            end
          end
          HZ_ST_DRAIN: begin
            ctrl = CTRL_BUBBLE;
            if (drn_cnt <= 4'd1) begin
              state_nx = HZ_ST_HALT;
              drn_nx   = '0;
            end else begin
              drn_nx = drn_cnt - 4'd1;
            end
          end
          default: begin
            ctrl = CTRL_NONE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (!ctrl.pc_en && state != HZ_ST_HALT && stall_count != '1) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

  assign bus.pc_en       = ctrl.pc_en;
  assign bus.if_id_en    = ctrl.if_id_en;
  assign bus.id_ex_en    = ctrl.id_ex_en;
  assign bus.ex_mem_en   = ctrl.ex_mem_en;
  assign bus.if_id_flush = ctrl.if_id_flush;
  assign bus.id_ex_flush = ctrl.id_ex_flush;
  // State is a flop with async reset, so this decode is a registered output.
  assign bus.halted      = (state == HZ_ST_HALT);
  assign dbg_state       = state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: two instances (1 and 3 load-use
// bubbles), stimulus pushes expected control/counter values, a monitor checks.
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

  localparam int W = 1 + 7 + 16;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_HALT   = 7'b0000000;

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, halted}
  localparam logic [6:0] V_RUN    = 7'b1111_00_0;
  localparam logic [6:0] V_BUB    = 7'b0011_01_0;
  localparam logic [6:0] V_REDIR  = 7'b1111_11_0;
  localparam logic [6:0] V_FREEZE = 7'b0000_00_0;
  localparam logic [6:0] V_HALT   = 7'b0000_00_1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if bus_a ();
  pipeline_hazard_ctrl_if bus_b ();
  logic [15:0] stall_count_a;
  logic [15:0] stall_count_b;
  hz_state_e   dbg_state_a;
  hz_state_e   dbg_state_b;

  pipeline_hazard_ctrl dut_a (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_a),
    .stall_count (stall_count_a),
    .dbg_state   (dbg_state_a)
  );

  pipeline_hazard_ctrl #(.LOAD_USE_BUBBLES(3), .DRAIN_CYCLES(4), .CNT_W(16)) dut_b (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_b),
    .stall_count (stall_count_b),
    .dbg_state   (dbg_state_b)
  );

  logic [6:0] ctl_a;
  logic [6:0] ctl_b;
  assign ctl_a = {bus_a.pc_en, bus_a.if_id_en, bus_a.id_ex_en, bus_a.ex_mem_en,
                  bus_a.if_id_flush, bus_a.id_ex_flush, bus_a.halted};
  assign ctl_b = {bus_b.pc_en, bus_b.if_id_en, bus_b.id_ex_en, bus_b.ex_mem_en,
                  bus_b.if_id_flush, bus_b.id_ex_flush, bus_b.halted};

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           mon_idx = 0;
  logic [15:0]  cnt_a = '0;
  logic [15:0]  cnt_b = '0;

  logic [6:0] in_opc;
  logic [4:0] in_rs1;
  logic [4:0] in_rs2;
  logic [4:0] in_rd;
  logic       in_ld;
  logic       in_redir;
  logic       in_req;
  logic       in_ack;
  logic       in_rst;

  // ---------------- driver tasks ----------------
  task automatic idle();
    in_opc = OPC_OP; in_rs1 = 5'd1; in_rs2 = 5'd2; in_rd = 5'd0;
    in_ld = 1'b0; in_redir = 1'b0; in_req = 1'b0; in_ack = 1'b0;
  endtask

  // One clock: drive the selected instance (the other sees a plain ADD),
  // push the expected response, then advance the stall-counter model.
  task automatic cyc(input bit sel, input logic [6:0] ev, input bit chk = 1'b1);
    @(posedge clk);
    #1;
    rst = in_rst;
    bus_a.id_opc      = sel ? OPC_OP : in_opc;
    bus_a.id_rs1      = sel ? 5'd1   : in_rs1;
    bus_a.id_rs2      = sel ? 5'd2   : in_rs2;
    bus_a.ex_is_load  = sel ? 1'b0   : in_ld;
    bus_a.ex_rd       = sel ? 5'd0   : in_rd;
    bus_a.ex_redirect = sel ? 1'b0   : in_redir;
    bus_a.dmem_req    = sel ? 1'b0   : in_req;
    bus_a.dmem_ack    = sel ? 1'b0   : in_ack;
    bus_b.id_opc      = sel ? in_opc   : OPC_OP;
    bus_b.id_rs1      = sel ? in_rs1   : 5'd1;
    bus_b.id_rs2      = sel ? in_rs2   : 5'd2;
    bus_b.ex_is_load  = sel ? in_ld    : 1'b0;
    bus_b.ex_rd       = sel ? in_rd    : 5'd0;
    bus_b.ex_redirect = sel ? in_redir : 1'b0;
    bus_b.dmem_req    = sel ? in_req   : 1'b0;
    bus_b.dmem_ack    = sel ? in_ack   : 1'b0;
    if (in_rst) begin
      cnt_a = '0;
      cnt_b = '0;
    end
    if (chk) exp_q.push_back({sel, ev, (sel ? cnt_b : cnt_a)});
    if (!in_rst && !ev[6] && !ev[0]) begin
      if (sel) begin
        if (cnt_b != 16'hFFFF) cnt_b = cnt_b + 16'd1;
      end else begin
        if (cnt_a != 16'hFFFF) cnt_a = cnt_a + 16'd1;
      end
    end
  endtask

  // ---------------- monitor ----------------
  logic [W-1:0] mon_e;
  logic [6:0]   act_ctl;
  logic [15:0]  act_cnt;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e   = exp_q.pop_front();
      act_ctl = mon_e[W-1] ? ctl_b : ctl_a;
      act_cnt = mon_e[W-1] ? stall_count_b : stall_count_a;
      n_cmp++;
      if (act_ctl !== mon_e[22:16]) begin
        n_err++;
        $display("FAIL ctl #%0d dut_%s: got %b want %b", mon_idx,
                 mon_e[W-1] ? "b" : "a", act_ctl, mon_e[22:16]);
      end
      n_cmp++;
      if (act_cnt !== mon_e[15:0]) begin
        n_err++;
        $display("FAIL stall_count #%0d dut_%s: got %h want %h", mon_idx,
                 mon_e[W-1] ? "b" : "a", act_cnt, mon_e[15:0]);
      end
      mon_idx++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    idle();
    in_rst = 1'b1;
    bus_a.id_opc = OPC_OP; bus_a.id_rs1 = 5'd1; bus_a.id_rs2 = 5'd2;
    bus_a.ex_is_load = 1'b0; bus_a.ex_rd = 5'd0; bus_a.ex_redirect = 1'b0;
    bus_a.dmem_req = 1'b0; bus_a.dmem_ack = 1'b0;
    bus_b.id_opc = OPC_OP; bus_b.id_rs1 = 5'd1; bus_b.id_rs2 = 5'd2;
    bus_b.ex_is_load = 1'b0; bus_b.ex_rd = 5'd0; bus_b.ex_redirect = 1'b0;
    bus_b.dmem_req = 1'b0; bus_b.dmem_ack = 1'b0;

    cyc(0, V_FREEZE); cyc(1, V_FREEZE);
    in_rst = 1'b0;
    cyc(0, V_RUN);

    // LW x5 in EX, ADD x6,x5,x1 in ID: one bubble
    in_ld = 1'b1; in_rd = 5'd5; in_rs1 = 5'd5; in_rs2 = 5'd1; cyc(0, V_BUB);
    idle(); cyc(0, V_RUN);
    // hazard through rs2 of an OP
    in_ld = 1'b1; in_rd = 5'd7; in_rs1 = 5'd1; in_rs2 = 5'd7; cyc(0, V_BUB);
    idle(); cyc(0, V_RUN);
    // false hazards: LW x0, LUI, OP-IMM rs2 field, JAL
    in_ld = 1'b1; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; cyc(0, V_RUN);
    in_rd = 5'd5; in_opc = OPC_LUI; in_rs1 = 5'd5; in_rs2 = 5'd5; cyc(0, V_RUN);
    in_opc = OPC_OP_IMM; in_rs1 = 5'd1; in_rs2 = 5'd5; cyc(0, V_RUN);
    in_opc = OPC_JAL; in_rs1 = 5'd5; in_rs2 = 5'd5; cyc(0, V_RUN);
    // real hazards: STORE rs2, BRANCH rs1
    in_opc = OPC_STORE; in_rs1 = 5'd2; in_rs2 = 5'd5; cyc(0, V_BUB);
    in_opc = OPC_BRANCH; in_rs1 = 5'd5; in_rs2 = 5'd3; cyc(0, V_BUB);
    // matching rd but not a load
    idle(); in_rd = 5'd5; in_rs1 = 5'd5; cyc(0, V_RUN);

    // redirect alone, then redirect beating a load-use
    idle(); in_redir = 1'b1; cyc(0, V_REDIR);
    idle(); cyc(0, V_RUN);
    in_redir = 1'b1; in_ld = 1'b1; in_rd = 5'd5; in_rs1 = 5'd5; cyc(0, V_REDIR);
    idle(); cyc(0, V_RUN);

    // dmem wait in RUN beats redirect
    in_req = 1'b1; cyc(0, V_FREEZE);
    in_redir = 1'b1; cyc(0, V_FREEZE);
    in_redir = 1'b0; in_ack = 1'b1; cyc(0, V_RUN);
    idle(); cyc(0, V_RUN);

    // halt, then redirect during DRAIN returns to RUN
    in_opc = OPC_HALT; cyc(0, V_BUB);
    cyc(0, V_BUB);
    in_redir = 1'b1; cyc(0, V_REDIR);
    idle(); cyc(0, V_RUN);

    // load-use and halt together: bubble first, then full drain
    in_opc = OPC_HALT; in_ld = 1'b1; in_rd = 5'd5; in_rs1 = 5'd5; cyc(0, V_BUB);
    in_ld = 1'b0; cyc(0, V_BUB);
    cyc(0, V_BUB); cyc(0, V_BUB); cyc(0, V_BUB);
    cyc(0, V_HALT);
    in_req = 1'b1; in_redir = 1'b1; cyc(0, V_HALT);
    idle(); cyc(0, V_HALT);

    in_rst = 1'b1; cyc(0, V_FREEZE); cyc(1, V_FREEZE);
    in_rst = 1'b0; cyc(0, V_RUN);

    // three-bubble instance
    cyc(1, V_RUN);
    in_ld = 1'b1; in_rd = 5'd5; in_rs1 = 5'd5; cyc(1, V_BUB);
    idle(); cyc(1, V_BUB); cyc(1, V_BUB); cyc(1, V_RUN);
    // dmem wait for 3 cycles inside LOAD_STALL
    in_ld = 1'b1; in_rd = 5'd5; in_rs1 = 5'd5; cyc(1, V_BUB);
    idle(); in_req = 1'b1; cyc(1, V_FREEZE); cyc(1, V_FREEZE); cyc(1, V_FREEZE);
    in_ack = 1'b1; cyc(1, V_BUB);
    idle(); cyc(1, V_BUB); cyc(1, V_RUN);
    // redirect cancels a pending stall
    in_ld = 1'b1; in_rd = 5'd5; in_rs1 = 5'd5; cyc(1, V_BUB);
    idle(); cyc(1, V_BUB);
    in_redir = 1'b1; cyc(1, V_REDIR);
    idle(); cyc(1, V_RUN);

    // saturate stall_count, then reset in the middle of DRAIN
    in_ld = 1'b1; in_rd = 5'd5; in_rs1 = 5'd5;
    for (int i = 0; i < 65540; i++) cyc(0, V_BUB, 1'b0);
    cyc(0, V_BUB); cyc(0, V_BUB);
    idle(); cyc(0, V_RUN);
    in_opc = OPC_HALT; cyc(0, V_BUB); cyc(0, V_BUB);
    in_rst = 1'b1; cyc(0, V_FREEZE);
    in_rst = 1'b0; idle(); cyc(0, V_RUN);
    in_ld = 1'b1; in_rd = 5'd5; in_rs1 = 5'd5; cyc(0, V_BUB);
    idle(); cyc(0, V_RUN);

    // ---------------- final report ----------------
    for (int k = 0; k < 8 && exp_q.size() != 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
